// File: rtl/controle_jogo_pkg.sv
// controle_jogo_pkg: state encoding, widths and the saturating BCD step for the game-flow sequencer.
package controle_jogo_pkg;
    typedef enum logic [2:0] {
        INICIO        = 3'd0,
        JOGANDO       = 3'd1,
        PAUSADO       = 3'd2,
        NAVE_ATINGIDA = 3'd3,
        FIM           = 3'd4
    } estado_t;
    localparam int BCD_DIGITOS = 4;
    localparam int TIMER_W = 8;
    // Carry ripples through nines; a carry out of the top digit means 9999, so hold.
    function automatic logic [4*BCD_DIGITOS-1:0] bcd_inc(input logic [4*BCD_DIGITOS-1:0] v);
        logic [4*BCD_DIGITOS-1:0] r;
        logic c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < BCD_DIGITOS; i++) begin
            if (c) begin
                c = (v[4*i+:4] == 4'd9);
                r[4*i+:4] = c ? 4'd0 : v[4*i+:4] + 4'd1;
            end
        end
        return c ? v : r;
    endfunction
endpackage

// File: rtl/contador_bcd.sv
// contador_bcd: 4-digit saturating BCD score counter with synchronous clear.
module contador_bcd
    import controle_jogo_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc,
    input  logic                     clr,
    output logic [4*BCD_DIGITOS-1:0] valor
);
    always_ff @(posedge clk or posedge rst)
        if (rst) valor <= '0;
        else if (clr) valor <= '0;
        else if (inc) valor <= bcd_inc(valor);
endmodule

// File: rtl/controle_jogo.sv
// controle_jogo: game-flow sequencer tracking state, lives, BCD score, level and the enemy respawn timer.
module controle_jogo
    import controle_jogo_pkg::*;
#(
    parameter int VIDAS_INICIAIS   = 3,
    parameter int FRAMES_RESPAWN   = 120,
    parameter int FRAMES_INIMIGO   = 60,
    parameter int FRAMES_FIM       = 180,
    parameter int PONTOS_POR_NIVEL = 10
)(
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        pausa,
    input  logic        frame_tick,
    input  logic        iniciar,
    input  logic        acerto_inimigo,
    input  logic        acerto_nave,
    output logic [2:0]  estado,
    output logic        jogo_ativo,
    output logic        reinicia_entidades,
    output logic        inimigo_vivo,
    output logic        perdeu,
    output logic [1:0]  vidas,
    output logic [15:0] pontos_bcd,
    output logic [3:0]  nivel
);
    localparam logic [TIMER_W-1:0] UM        = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] T_RESPAWN = TIMER_W'(FRAMES_RESPAWN);
    localparam logic [TIMER_W-1:0] T_INIMIGO = TIMER_W'(FRAMES_INIMIGO);
    localparam logic [TIMER_W-1:0] T_FIM     = TIMER_W'(FRAMES_FIM);
    localparam logic [1:0]         V_INI     = 2'(VIDAS_INICIAIS);
    localparam logic [7:0]         K_MAX     = 8'(PONTOS_POR_NIVEL - 1);

    estado_t st, st_n, ret, ret_n;
    logic p1, p2;
    logic [TIMER_W-1:0] tmr, tmr_n, tmr_ini, tmr_ini_n;
    logic [7:0] kills, kills_n;
    logic [1:0] vidas_n;
    logic [3:0] nivel_n;
    logic vivo_n, reinicia_n, inicia, mata;

    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset) begin
            st  <= INICIO;
            ret <= JOGANDO;
        end else begin
            st  <= st_n;
            ret <= ret_n;
        end

    always_comb begin
        st_n       = st;
        ret_n      = ret;
        tmr_n      = tmr;
        tmr_ini_n  = tmr_ini;
        vidas_n    = vidas;
        vivo_n     = inimigo_vivo;
        kills_n    = kills;
        nivel_n    = nivel;
        reinicia_n = 1'b0;
        inicia     = 1'b0;
        mata       = 1'b0;
        case (st)
            INICIO: inicia = iniciar;
            JOGANDO: begin
                mata = acerto_inimigo && inimigo_vivo;
                if (acerto_nave) begin
                    vidas_n = vidas - 2'd1;
                    st_n    = (vidas > 2'd1) ? NAVE_ATINGIDA : FIM;
                    tmr_n   = (vidas > 2'd1) ? T_RESPAWN : T_FIM;
                end else if (p2) begin
                    st_n  = PAUSADO;
                    ret_n = JOGANDO;
                end
                if (!inimigo_vivo && frame_tick) begin
                    tmr_ini_n = tmr_ini - UM;
                    vivo_n    = (tmr_ini == UM);
                end
            end
            PAUSADO: st_n = p2 ? PAUSADO : ret;
            NAVE_ATINGIDA:
                if (p2) begin
                    st_n  = PAUSADO;
                    ret_n = NAVE_ATINGIDA;
                end else if (frame_tick) begin
                    tmr_n      = tmr - UM;
                    st_n       = (tmr == UM) ? JOGANDO : NAVE_ATINGIDA;
                    reinicia_n = (tmr == UM);
                end
            FIM: begin
                inicia = iniciar && (tmr == '0);
                if (frame_tick && tmr != '0) tmr_n = tmr - UM;
            end
            default: st_n = INICIO;
        endcase
        // A kill that wraps the per-level counter advances the level, capped at 15.
        if (mata) begin
            vivo_n    = 1'b0;
            tmr_ini_n = T_INIMIGO;
            kills_n   = (kills == K_MAX) ? 8'd0 : kills + 8'd1;
            nivel_n   = (kills == K_MAX && nivel != 4'd15) ? nivel + 4'd1 : nivel;
        end
        if (inicia) begin
            st_n       = JOGANDO;
            vidas_n    = V_INI;
            nivel_n    = 4'd0;
            kills_n    = 8'd0;
            vivo_n     = 1'b1;
            tmr_ini_n  = '0;
            reinicia_n = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset) begin
            p1                 <= 1'b0;
            p2                 <= 1'b0;
            tmr                <= '0;
            tmr_ini            <= '0;
            kills              <= 8'd0;
            vidas              <= V_INI;
            nivel              <= 4'd0;
            inimigo_vivo       <= 1'b1;
            reinicia_entidades <= 1'b0;
            jogo_ativo         <= 1'b0;
            perdeu             <= 1'b0;
        end else begin
            p1                 <= pausa;
            p2                 <= p1;
            tmr                <= tmr_n;
            tmr_ini            <= tmr_ini_n;
            kills              <= kills_n;
            vidas              <= vidas_n;
            nivel              <= nivel_n;
            inimigo_vivo       <= vivo_n;
            reinicia_entidades <= reinicia_n;
            jogo_ativo         <= (st_n == JOGANDO);
            perdeu             <= (st_n == FIM);
        end

    contador_bcd u_pontos (
        .clk  (CLOCK_50),
        .rst  (reset),
        .inc  (mata),
        .clr  (inicia),
        .valor(pontos_bcd)
    );

    assign estado = st;
endmodule

// File: doc/controle_jogo.md
# controle_jogo

Game-flow sequencer for the shooter design. It sits between the input/collision sources (`keys`, `entities`) and the consumers (`entities`, `tela`, HEX drivers). It decides when entities may move, when they are reinitialised, and when the enemy is drawn. It also tracks lives, BCD score and level, and drives the `perdeu` flag that `tela` consumes.

## Interface
- `VIDAS_INICIAIS`, default 3: lives at game start; range 1–3.
- `FRAMES_RESPAWN`, default 120: frames the ship stays down after a hit.
- `FRAMES_INIMIGO`, default 60: frames before a destroyed enemy reappears.
- `FRAMES_FIM`, default 180: minimum frames in FIM before `iniciar` is accepted.
- `PONTOS_POR_NIVEL`, default 10: kills per level step.

Ports:
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `pausa`  in  1  pause switch; asynchronous level, synchronised internally.
- `frame_tick`  in  1  one-cycle pulse per video frame, at the start of vertical blank.
- `iniciar`  in  1  one-cycle pulse, start/restart request from `keys`.
- `acerto_inimigo`  in  1  one-cycle pulse: allied ball hit the enemy.
- `acerto_nave`  in  1  one-cycle pulse: enemy ball hit the ship.
- `estado`  out  3  current state encoding.
- `jogo_ativo`  out  1  entities may update positions.
- `reinicia_entidades`  out  1  one-cycle pulse: reload entity start positions.
- `inimigo_vivo`  out  1  enemy is drawn and collidable.
- `perdeu`  out  1  game-over screen select.
- `vidas`  out  2  remaining lives.
- `pontos_bcd`  out  16  score, 4 BCD digits, MSD in [15:12].
- `nivel`  out  4  current level, starting at 0.

## Operation
- States:
  - INICIO (0): idle; `iniciar` → JOGANDO, loads `vidas`=VIDAS_INICIAIS, score=0, `nivel`=0, pulses `reinicia_entidades`.
  - JOGANDO (1): `jogo_ativo`=1.
    - Synchronised `pausa`=1 → PAUSADO.
    - `acerto_nave` with `vidas`>1 → NAVE_ATINGIDA, `vidas`−1.
    - `acerto_nave` with `vidas`=1 → FIM, `vidas`=0.
  - PAUSADO (2): all counters frozen, including the frame timers. Synchronised `pausa`=0 → the state held before pausing. If entered from NAVE_ATINGIDA, the return is to NAVE_ATINGIDA.
  - NAVE_ATINGIDA (3): `jogo_ativo`=0. Counts FRAMES_RESPAWN `frame_tick`s, then pulses `reinicia_entidades` → JOGANDO.
  - FIM (4): `perdeu`=1. Counts FRAMES_FIM ticks; `iniciar` is ignored until the count expires. After expiry, `iniciar` behaves as in INICIO.
- Enemy sub-timer, independent of the main state but frozen outside JOGANDO:
  - `acerto_inimigo` while `inimigo_vivo`=1 clears `inimigo_vivo` and increments the score.
  - After FRAMES_INIMIGO ticks, `inimigo_vivo` is set to 1 again.
  - `acerto_inimigo` while `inimigo_vivo`=0 is ignored.
- Score is BCD and saturates at 9999.
- Kill counter mod PAUSADO-independent PONTOS_POR_NIVEL: when it wraps, `nivel`+1, saturating at 15.
- Same-cycle `acerto_inimigo` and `acerto_nave` in JOGANDO: both apply. The score is credited, then the life is lost. On the final life the credited score is kept in FIM.
- `acerto_*` outside JOGANDO are ignored.
- `reset` mid-game: immediate return to INICIO; all counters cleared.

## Timing
- Reset values:
  - `estado`=INICIO
  - `jogo_ativo`=0
  - `reinicia_entidades`=0
  - `inimigo_vivo`=1
  - `perdeu`=0
  - `vidas`=VIDAS_INICIAIS
  - `pontos_bcd`=0
  - `nivel`=0
- All outputs are registered. An input pulse sampled at edge N is visible after edge N, i.e. one cycle of latency.
- `pausa` uses a 2-flop synchroniser. The state change occurs on the third rising edge after `pausa` settles.
- Timers decrement only on `frame_tick`.
  - Expiry is the tick that brings the count to 0.
  - The transition is registered on that same edge.
- `reinicia_entidades` is high for exactly one cycle, coincident with entry to JOGANDO.
- `iniciar` pulses are single-cycle. A pulse arriving in a cycle with no eligible transition is dropped, not queued.

## Structure
- Package `controle_jogo_pkg`:
  - state enum (3-bit) and its encodings
  - `BCD_DIGITOS`=4
  - timer width constant of 8 bits, which covers FRAMES_* ≤ 255
- Sub-module `contador_bcd`: 4-digit saturating BCD incrementer with `inc` and `clr` inputs and a 16-bit output.
- Timers, synchroniser and FSM stay in `controle_jogo`.

## Test plan
- Reset, then `iniciar` → `estado`=1, `vidas`=3, `reinicia_entidades` high for one cycle, `jogo_ativo`=1.
- 12 `acerto_inimigo` pulses, each followed by 60 `frame_tick`s → `pontos_bcd`=0x0012, `nivel`=1, `inimigo_vivo`=1.
- `acerto_nave` three times, each after respawn → `vidas` goes 2, 1, 0.
  - After the first and second hits: NAVE_ATINGIDA for 120 ticks, then `reinicia_entidades` pulse.
  - After the third hit: `estado`=4, `perdeu`=1.
- In FIM, `iniciar` at tick 100 → ignored. `iniciar` at tick 181 → JOGANDO, score 0, `vidas`=3.
- `pausa`=1 during NAVE_ATINGIDA at tick 50 → timer frozen over 500 ticks. After release, 70 more ticks → JOGANDO.
- Simultaneous `acerto_inimigo`+`acerto_nave` with `vidas`=1 → FIM, `pontos_bcd` incremented by 1.
- Score preloaded to 9999, then `acerto_inimigo` → `pontos_bcd` stays 0x9999.
